// File: rtl/out_uart_tx_pkg.sv
// Shared constants and FSM state type for the CPU output-port UART printer.
package out_uart_tx_pkg;

  localparam logic       UART_IDLE   = 1'b1;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A_M10 = 8'h37;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/out_uart_tx_if.sv
// CPU output-port strobe and word, as seen by the UART printer.
interface out_uart_tx_if #(
  parameter int DATA_W = 16
);

  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data);
  modport slave  (input  out_valid, input  out_data);

endinterface

// File: rtl/out_fifo.sv
// Word buffer between the CPU output port and the UART serialiser.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module out_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         push_data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer advance (natural wrap, DEPTH is a power of two) and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and count
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; only accepted pushes write, so out_data is never looked at otherwise
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/out_uart_tx.sv
// Prints every CPU OUT word on a UART line as four uppercase hex digits plus LF,
// most significant nibble first. The CPU is never stalled: words that find the
// FIFO full are dropped and remembered in a sticky overflow flag.
module out_uart_tx
  import out_uart_tx_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         rst,
  out_uart_tx_if.slave cpu,
  output logic         tx,
  output logic         busy,
  output logic         fifo_full,
  output logic         overflow
);

  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_CHAR = 3'd4;
  localparam logic [2:0]        LAST_BIT  = 3'd7;

  // 8-bit ASCII for one hex digit; sums are kept to 8 bits
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n <= 4'd9) return ASCII_0 + n8;
    return ASCII_A_M10 + n8;
  endfunction

  tx_state_t         state_q, state_d;
  logic [2:0]        char_idx_q, char_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [15:0]       word_q, word_d;
  logic [7:0]        byte_q, byte_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        nibble;
  logic              bit_end;

  logic [15:0]       fifo_head;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_drop;
  logic [CNT_W-1:0]  fifo_count;

  out_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (16)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (cpu.out_valid),
    .push_data_i (cpu.out_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  assign bit_end    = (baud_q == BAUD_LAST);
  assign overflow_d = overflow_q | fifo_drop;

  // Nibble of the held word for the current character, MSB nibble first
  always_comb begin
    nibble = word_q[15:12];
    case (char_idx_q[1:0])
      2'd0:    nibble = word_q[15:12];
      2'd1:    nibble = word_q[11:8];
      2'd2:    nibble = word_q[7:4];
      default: nibble = word_q[3:0];
    endcase
  end

  // Frame sequencer: next state, counters, word/byte loads and FIFO pop
  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    word_d     = word_q;
    byte_d     = byte_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_head;
          char_idx_d = 3'd0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        byte_d  = (char_idx_q == LAST_CHAR) ? ASCII_LF : hex_ascii(nibble);
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (char_idx_q == LAST_CHAR) begin
            state_d = IDLE;
          end else begin
            char_idx_d = char_idx_q + 3'd1;
            state_d    = LOAD;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level implied by the current state; registered below so tx never glitches
  always_comb begin
    tx_d = UART_IDLE;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_q[bit_idx_q];
      default: tx_d = UART_IDLE;
    endcase
  end

  // Control registers; reset drops the line high at once and abandons any frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      tx_q       <= UART_IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  // Data registers: popped word and the character being shifted out
  always_ff @(posedge clk) begin
    word_q <= word_d;
    byte_q <= byte_d;
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (fifo_count != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: a word-level model predicts the line waveform and flags,
// a mid-bit UART receiver decodes characters, and directed cases pin exact values.
module tb_out_uart_tx;

  localparam int         CPB   = 4;
  localparam int         DEPTH = 8;
  localparam logic [7:0] C0    = "0";
  localparam logic [7:0] CA    = "A";
  localparam logic [7:0] LF    = 8'd10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, busy, fifo_full, overflow;

  out_uart_tx_if cpu_if ();

  out_uart_tx #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu_if.slave),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: queued words, remaining line levels of the word being printed,
  // characters still to be received, and the expected outputs after each edge.
  logic [15:0] mq   [$];
  logic        lvl_q[$];
  logic [7:0]  expq [$];
  logic [7:0]  rxq  [$];
  logic        m_tx   = 1'b1;
  logic        m_lvl  = 1'b1;
  logic        m_act  = 1'b0;
  logic        m_ovf  = 1'b0;
  int          mon_cnt = -1;
  logic [7:0]  mon_byte = 8'h00;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? C0 + 8'(n) : CA + 8'(n) - 8'd10;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // A word becomes five characters; each is one high gap clock, then start,
  // eight data bits LSB first and a stop bit, each CPB clocks long.
  task automatic model_load(input logic [15:0] w);
    logic [7:0] ch;
    for (int c = 0; c < 5; c++) begin
      ch = (c < 4) ? hexc(4'(w >> (12 - 4 * c))) : LF;
      expq.push_back(ch);
      lvl_q.push_back(1'b1);
      repeat (CPB) lvl_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (CPB) lvl_q.push_back(ch[b]);
      repeat (CPB) lvl_q.push_back(1'b1);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    lvl_q.delete();
    expq.delete();
    m_tx  = 1'b1;
    m_lvl = 1'b1;
    m_act = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One clock edge: continue the current word, spend one idle edge after it,
  // or start the next queued word; then offer the strobed word to the queue.
  task automatic model_edge();
    logic lvl, act;
    if (lvl_q.size() > 0) begin
      lvl = lvl_q.pop_front();
      act = 1'b1;
    end else if (m_act) begin
      lvl = 1'b1;
      act = 1'b0;
    end else if (mq.size() > 0) begin
      model_load(mq.pop_front());
      lvl = lvl_q.pop_front();
      act = 1'b1;
    end else begin
      lvl = 1'b1;
      act = 1'b0;
    end
    m_tx  = m_lvl;
    m_lvl = lvl;
    m_act = act;
    if (cpu_if.out_valid) begin
      if (mq.size() < DEPTH) mq.push_back(cpu_if.out_data);
      else m_ovf = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_edge();
    end
  end

  // Compare outputs with the model every cycle, and decode the line mid-bit
  initial begin
    forever begin
      @(negedge clk);
      chk("tx", 32'(tx), 32'(m_tx));
      chk("busy", 32'(busy), 32'(m_act || (mq.size() != 0)));
      chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (!rst) begin
        mon_cnt = -1;
      end else if (mon_cnt < 0) begin
        if (tx == 1'b0) begin
          mon_cnt  = 0;
          mon_byte = 8'h00;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= CPB + CPB / 2 && mon_cnt < 9 * CPB &&
            ((mon_cnt - CPB - CPB / 2) % CPB) == 0) begin
          mon_byte[(mon_cnt - CPB - CPB / 2) / CPB] = tx;
        end else if (mon_cnt == 9 * CPB + CPB / 2) begin
          chk("stop_bit", 32'(tx), 32'd1);
          if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_byte: got %02h, wanted no character", mon_byte);
          end else begin
            chk("rx_byte", 32'(mon_byte), 32'(expq.pop_front()));
          end
          rxq.push_back(mon_byte);
          mon_cnt = -1;
        end
      end
    end
  end

  task automatic push(input logic [15:0] w);
    cpu_if.out_valid = 1'b1;
    cpu_if.out_data  = w;
    @(negedge clk);
    cpu_if.out_valid = 1'b0;
    cpu_if.out_data  = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rxq.delete();
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    int n;
    n = 0;
    while ((busy || mon_cnt >= 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (busy || mon_cnt >= 0) begin
      n_err++;
      $display("FAIL %s: still busy after %0d clk, wanted idle", nm, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_rx(input string nm, input logic [79:0] exp, input int n);
    chk({nm, "_count"}, 32'(rxq.size()), 32'(n));
    for (int i = 0; i < n && i < rxq.size(); i++)
      chk(nm, 32'(rxq[i]), 32'(exp[8 * (n - 1 - i) +: 8]));
  endtask

  task automatic chk_seg(input string nm, input int base, input logic [39:0] exp);
    for (int i = 0; i < 5; i++) begin
      if (base + i < rxq.size()) chk(nm, 32'(rxq[base + i]), 32'(exp[8 * (4 - i) +: 8]));
      else chk({nm, "_missing"}, 32'(rxq.size()), 32'(base + 5));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, wanted finish");
    $fatal(1);
  end

  initial begin
    int t, t_fall;
    cpu_if.out_valid = 1'b0;
    cpu_if.out_data  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single word: tx falls on the 3rd edge after the strobe; the pop is one
    // edge after the strobe and printing takes 5 x (1 + 10*CPB) = 205 clocks.
    rxq.delete();
    push(16'h1234);
    t = 0;
    t_fall = -1;
    while (t < 400) begin
      if (tx == 1'b0 && t_fall < 0) t_fall = t;
      if (!busy) break;
      @(negedge clk);
      t++;
    end
    chk("t1_tx_fall", 32'(t_fall), 32'd3);
    chk("t1_busy_after_pop", 32'(t - 1), 32'd205);
    wait_quiet("t1_idle", 100);
    chk_rx("t1_bytes", 80'h31_32_33_34_0A, 5);

    // Two words on consecutive edges
    rxq.delete();
    push(16'hABCD);
    push(16'h0F09);
    wait_quiet("t2_idle", 800);
    chk_rx("t2_bytes", 80'h41_42_43_44_0A_30_46_30_39_0A, 10);

    // Ten strobes in a row from idle: one popped, eight buffered, one dropped
    rxq.delete();
    for (int i = 0; i < 10; i++) push(16'h1000 + 16'(i));
    chk("t3_full", 32'(fifo_full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    wait_quiet("t3_idle", 2500);
    chk("t3_count", 32'(rxq.size()), 32'd45);
    chk_seg("t3_first", 0, 40'h31_30_30_30_0A);
    chk_seg("t3_last", 40, 40'h31_30_30_38_0A);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Strobe exactly on the edge that pops a full FIFO: accepted, no overflow.
    // Word 0 pops one edge after its strobe, frees the line 205 edges later
    // and the next pop is one idle edge after that: edge 207 from strobe 0.
    do_reset();
    for (int i = 0; i < 9; i++) push(16'h2000 + 16'(i));
    repeat (198) @(negedge clk);
    chk("t4_full_before", 32'(fifo_full), 32'd1);
    push(16'h2009);
    chk("t4_full_after", 32'(fifo_full), 32'd1);
    chk("t4_ovf", 32'(overflow), 32'd0);
    wait_quiet("t4_idle", 2500);
    chk("t4_count", 32'(rxq.size()), 32'd50);
    chk_seg("t4_last", 45, 40'h32_30_30_39_0A);
    chk("t4_ovf_end", 32'(overflow), 32'd0);

    // Reset during data bit 3 of the second character, one word still queued
    do_reset();
    push(16'h1234);
    push(16'hBEEF);
    repeat (59) @(negedge clk);
    chk("t5_bit3_of_2", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(tx), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_full", 32'(fifo_full), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(16'h5A5A);
    wait_quiet("t5_idle", 400);
    chk_rx("t5_bytes", 80'h31_35_41_35_41_0A, 6);

    // Data bus noise with no strobe
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cpu_if.out_data = (i % 2 == 0) ? 16'hxxxx : 16'($urandom);
    end
    chk("t6_tx", 32'(tx), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rx_none", 32'(rxq.size()), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
